mem_access_unit: RTL and testbench

//  Memory-stage responder for the decoder's load/store controls (MemoryRE, MemoryWE, SizeOut, Unsigned).

---
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_access_unit.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Word-only data memory bus between the memory stage and data RAM.
// req/ack handshake; the master holds request fields until ack.
interface mem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store responder: big-endian lane extract/merge,
// sub-word read-modify-write, alignment faults and ack timeout.
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              MemoryRE,
  input  logic              MemoryWE,
  input  logic [1:0]        SizeOut,
  input  logic              Unsigned,
  input  logic [31:0]       Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall,
  output logic              Done,
  output logic              Misaligned,
  output logic              BusError,
  mem_access_unit_if.master mem
);

  localparam int CW = $clog2(ACK_TIMEOUT + 2);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RMW_RD,
    WR,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [15:0] sdata_q, sdata_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        req_any;
  logic        fault;
  logic        busy;
  logic        ack;
  logic        tmo_hit;
  logic [4:0]  sh_b;
  logic [4:0]  sh_h;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_ext;
  logic [31:0] lane_mask;
  logic [31:0] lane_ins;
  logic [31:0] merged;

  assign req_any = MemoryRE | MemoryWE;
  assign fault   = (SizeOut == 2'b01 && Address[0])
                 | (SizeOut[1] && Address[1:0] != 2'b00);
  assign busy    = state_q inside {RD, RMW_RD, WR};
  assign ack     = busy & mem.mem_ack;
  assign tmo_hit = (ACK_TIMEOUT != 0) && busy
                 && !mem.mem_ack
                 && (cnt_q == CW'(ACK_TIMEOUT - 1));

  // Lane k sits at bits [31-8k -: 8], so the shift is 8*(3-k).
  always_comb begin
    sh_b   = {~off_q, 3'b000};
    sh_h   = {~off_q[1], 4'b0000};
    byte_v = 8'(mem.mem_rdata >> sh_b);
    half_v = 16'(mem.mem_rdata >> sh_h);
    ld_ext = mem.mem_rdata;
    unique case (1'b1)
      size_q == 2'b00:
        ld_ext = {{24{~uns_q & byte_v[7]}}, byte_v};
      size_q == 2'b01:
        ld_ext = {{16{~uns_q & half_v[15]}}, half_v};
      size_q[1]:
        ld_ext = mem.mem_rdata;
    endcase
    if (size_q == 2'b00) begin
      lane_mask = 32'h0000_00FF << sh_b;
      lane_ins  = {24'h0, sdata_q[7:0]} << sh_b;
    end else begin
      lane_mask = 32'h0000_FFFF << sh_h;
      lane_ins  = {16'h0, sdata_q} << sh_h;
    end
    merged = (mem.mem_rdata & ~lane_mask) | lane_ins;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    sdata_d = sdata_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    cnt_d   = cnt_q;
    if (busy && !mem.mem_ack && ACK_TIMEOUT != 0)
      cnt_d = cnt_q + CW'(1);

    unique case (state_q)
      IDLE: begin
        if (req_any && fault) begin
          mis_d   = 1'b1;
          rdata_d = '0;
        end else if (req_any) begin
          addr_d  = Address[31:2];
          off_d   = Address[1:0];
          size_d  = SizeOut;
          uns_d   = Unsigned;
          sdata_d = WriteData[15:0];
          rdata_d = '0;
          // A store wins when both requests are raised.
          unique case (1'b1)
            !MemoryWE:
              state_d = RD;
            MemoryWE && SizeOut[1]: begin
              state_d = WR;
              wdata_d = WriteData;
            end
            MemoryWE && !SizeOut[1]:
              state_d = RMW_RD;
          endcase
        end
      end
      RD: begin
        if (ack) begin
          state_d = DONE;
          rdata_d = ld_ext;
        end else if (tmo_hit) begin
          state_d = DONE;
          berr_d  = 1'b1;
          rdata_d = '0;
        end
      end
      RMW_RD: begin
        if (ack) begin
          state_d = WR;
          wdata_d = merged;
        end else if (tmo_hit) begin
          state_d = DONE;
          berr_d  = 1'b1;
          rdata_d = '0;
        end
      end
      WR: begin
        if (ack) begin
          state_d = DONE;
        end else if (tmo_hit) begin
          state_d = DONE;
          berr_d  = 1'b1;
          rdata_d = '0;
        end
      end
      DONE:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase

    if (state_d != state_q)
      cnt_d = '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      sdata_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      sdata_q <= sdata_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Stall = (state_q == IDLE && req_any && !fault)
               | busy;
  assign Done       = state_q == DONE;
  assign ReadData   = rdata_q;
  assign Misaligned = mis_q;
  assign BusError   = berr_q;

  assign mem.mem_req   = busy;
  assign mem.mem_we    = state_q == WR;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized check of mem_access_unit against a byte-array
// reference model and a simple word memory responder.
module tb_mem_access_unit;
  localparam int TMO = 16;
  localparam int NEVER = 255;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        MemoryRE = 1'b0;
  logic        MemoryWE = 1'b0;
  logic [1:0]  SizeOut = 2'b00;
  logic        Unsigned = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Done;
  logic        Misaligned;
  logic        BusError;

  mem_access_unit_if bus();

  mem_access_unit #(.ACK_TIMEOUT(TMO)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .MemoryRE  (MemoryRE),
    .MemoryWE  (MemoryWE),
    .SizeOut   (SizeOut),
    .Unsigned  (Unsigned),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Done      (Done),
    .Misaligned(Misaligned),
    .BusError  (BusError),
    .mem       (bus)
  );

  always #5 Clock = ~Clock;

  int n_err = 0;
  int n_chk = 0;
  int ack_dly = 0;
  int wait_cnt = 0;
  int wr_cnt = 0;
  logic [31:0] tb_mem [64];
  logic [31:0] ref_mem [64];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Responder: ack after ack_dly wait cycles of each request.
  always @(negedge Clock) begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    if (bus.mem_req === 1'b1 && ack_dly != NEVER
        && wait_cnt >= ack_dly) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = tb_mem[bus.mem_addr[5:0]];
    end
  end

  always @(posedge Clock) begin
    if (bus.mem_req === 1'b1) begin
      if (bus.mem_ack === 1'b1) begin
        if (bus.mem_we === 1'b1) begin
          tb_mem[bus.mem_addr[5:0]] = bus.mem_wdata;
          wr_cnt++;
        end
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  function automatic logic [31:0] ref_load(
    input logic [31:0] w, input logic [1:0] sz,
    input bit uns, input logic [1:0] a);
    logic [7:0] b [4];
    logic [31:0] v;
    for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
    if (sz == 2'b00) begin
      v = {24'h0, b[a]};
      if (!uns && b[a][7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = {16'h0, b[{a[1], 1'b0}], b[{a[1], 1'b1}]};
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(
    input logic [31:0] w, input logic [1:0] sz,
    input logic [1:0] a, input logic [31:0] wd);
    logic [7:0] b [4];
    if (sz[1]) return wd;
    for (int i = 0; i < 4; i++) b[i] = w[31-8*i -: 8];
    if (sz == 2'b00) begin
      b[a] = wd[7:0];
    end else begin
      b[{a[1], 1'b0}] = wd[15:8];
      b[{a[1], 1'b1}] = wd[7:0];
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  task automatic set_word(input int idx, input logic [31:0] v);
    tb_mem[idx]  = v;
    ref_mem[idx] = v;
  endtask

  task automatic do_op(input bit re, input bit we,
                       input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr,
                       input logic [31:0] wd, input int d);
    bit fault, tmo, seen;
    int idx, exp_stall, stall_n, w0;
    logic [31:0] exp_rd;
    fault = (sz == 2'b01 && addr[0])
         || (sz[1] && addr[1:0] != 2'b00);
    tmo    = !fault && d == NEVER;
    idx    = int'(addr[7:2]);
    exp_rd = '0;
    if (!fault && !tmo) begin
      if (we) ref_mem[idx] = ref_store(ref_mem[idx], sz, addr[1:0], wd);
      else exp_rd = ref_load(ref_mem[idx], sz, uns, addr[1:0]);
    end
    if (fault) exp_stall = 0;
    else if (tmo) exp_stall = 1 + TMO;
    else if (we && !sz[1]) exp_stall = 1 + 2 * (d + 1);
    else exp_stall = 1 + (d + 1);

    @(negedge Clock);
    MemoryRE = re; MemoryWE = we; SizeOut = sz;
    Unsigned = uns; Address = addr; WriteData = wd;
    ack_dly = d; w0 = wr_cnt;
    #1 stall_n = Stall ? 1 : 0;
    @(posedge Clock); #1;
    MemoryRE = 1'b0; MemoryWE = 1'b0;

    if (fault) begin
      chk("misaligned", {31'h0, Misaligned}, 1);
      chk("fault_req", {31'h0, bus.mem_req}, 0);
      chk("fault_rdata", ReadData, 0);
      chk("fault_stall", stall_n, 0);
      @(posedge Clock); #1;
      chk("mis_pulse", {31'h0, Misaligned}, 0);
      chk("fault_writes", wr_cnt - w0, 0);
    end else begin
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
        if (Done) seen = 1'b1;
        else begin
          stall_n += Stall ? 1 : 0;
          @(posedge Clock); #1;
        end
      end
      chk("done_seen", {31'h0, seen}, 1);
      chk("stall_cycles", stall_n, exp_stall);
      chk("bus_error", {31'h0, BusError}, {31'h0, tmo});
      chk("no_misalign", {31'h0, Misaligned}, 0);
      if (!we || tmo) chk("read_data", ReadData, exp_rd);
      chk("mem_word", tb_mem[idx], ref_mem[idx]);
      chk("writes", wr_cnt - w0, (we && !tmo) ? 1 : 0);
      @(posedge Clock); #1;
      chk("done_pulse", {31'h0, Done}, 0);
    end
  endtask

  initial begin
    int w0;
    bit re, we;
    int d;
    for (int i = 0; i < 64; i++) set_word(i, $urandom);

    repeat (2) @(posedge Clock);
    #1;
    chk("rst_rdata", ReadData, 0);
    chk("rst_stall", {31'h0, Stall}, 0);
    chk("rst_done", {31'h0, Done}, 0);
    chk("rst_mis", {31'h0, Misaligned}, 0);
    chk("rst_berr", {31'h0, BusError}, 0);
    chk("rst_req", {31'h0, bus.mem_req}, 0);
    chk("rst_we", {31'h0, bus.mem_we}, 0);
    chk("rst_addr", {2'b0, bus.mem_addr}, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    Reset = 1'b0;

    set_word(4, 32'hDEAD_BEEF);
    do_op(1, 0, 2'b10, 0, 32'h10, 0, 0);
    set_word(4, 32'h1122_33F0);
    do_op(1, 0, 2'b00, 0, 32'h13, 0, 0);
    do_op(1, 0, 2'b00, 1, 32'h13, 0, 1);
    set_word(8, 32'h1122_3344);
    do_op(0, 1, 2'b01, 0, 32'h22, 32'h0000_ABCD, 0);
    do_op(1, 0, 2'b10, 0, 32'h05, 0, 0);
    do_op(0, 1, 2'b01, 0, 32'h01, 32'h1234, 0);
    do_op(1, 0, 2'b10, 0, 32'h30, 0, NEVER);
    do_op(0, 1, 2'b00, 0, 32'h31, 32'h77, NEVER);
    do_op(1, 1, 2'b11, 0, 32'h40, 32'hCAFE_F00D, 2);

    // Reset while the sub-word store waits in its read phase.
    @(negedge Clock);
    MemoryWE = 1'b1; SizeOut = 2'b00;
    Address = 32'h41; WriteData = 32'h5A;
    ack_dly = NEVER; w0 = wr_cnt;
    @(posedge Clock); #1;
    MemoryWE = 1'b0;
    chk("rmw_req", {31'h0, bus.mem_req}, 1);
    chk("rmw_we", {31'h0, bus.mem_we}, 0);
    @(negedge Clock); Reset = 1'b1;
    @(posedge Clock); #1; Reset = 1'b0;
    chk("mid_rst_req", {31'h0, bus.mem_req}, 0);
    chk("mid_rst_stall", {31'h0, Stall}, 0);
    chk("mid_rst_done", {31'h0, Done}, 0);
    chk("mid_rst_addr", {2'b0, bus.mem_addr}, 0);
    repeat (3) @(posedge Clock);
    #1;
    chk("mid_rst_req2", {31'h0, bus.mem_req}, 0);
    chk("mid_rst_writes", wr_cnt - w0, 0);
    chk("mid_rst_mem", tb_mem[16], ref_mem[16]);

    for (int k = 0; k < 80; k++) begin
      re = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      if (!re && !we) re = 1'b1;
      d = ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(0, 3));
      do_op(re, we, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))},
            $urandom, d);
    end

    for (int i = 0; i < 64; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
